or_out_capture: RTL and testbench

- Receive-side capture block for the OR_out bus: samples the result word y driven by the OR gate DUT every clock.
- Detects value changes and buffers each change event, with optional timestamp, in a small FIFO.
- Events are presented to a downstream consumer over a valid/ready read port.
- Sits at the far end of the OR_out bus: a synthesizable reader for on-chip checking and debug capture.

---
 rtl/or_out_capture_pkg.sv | 28 ++
 rtl/or_out_capture_fifo.sv | 66 ++++++
 rtl/or_out_capture.sv | 135 +++++++++++++
 tb/tb_or_out_capture.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/or_out_capture_pkg.sv
// -----------------------------------------------------------------------------
// or_out_capture_pkg
// Shared constants and types for the OR_out bus capture block.
//   OR_OUT_WIDTH_DEF : default width of the captured y word
//   DEPTH_DEF        : default event FIFO depth (power of 2, >= 2)
//   TS_WIDTH_DEF     : default timestamp counter width
//   ptr_w()          : FIFO pointer / occupancy width (one extra MSB so that
//                      full and empty can be told apart)
//   entry_t          : one captured event at the default widths {data, ts}
// -----------------------------------------------------------------------------
package or_out_capture_pkg;

  localparam int OR_OUT_WIDTH_DEF = 8;
  localparam int DEPTH_DEF        = 8;
  localparam int TS_WIDTH_DEF     = 16;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PTR_W_DEF = ptr_w(DEPTH_DEF);

  typedef struct packed {
    logic [OR_OUT_WIDTH_DEF-1:0] data;
    logic [TS_WIDTH_DEF-1:0]     ts;
  } entry_t;

endpackage

// File: rtl/or_out_capture_fifo.sv
// -----------------------------------------------------------------------------
// or_out_capture_fifo
// Synchronous first-word-fall-through FIFO holding captured events.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset (flushes the FIFO)
//   push, wr_data : write request and entry; ignored when full unless a pop
//                   happens in the same cycle
//   pop           : remove the head entry; ignored when empty
//   rd_data       : head entry, all zeros when empty
//   full, empty   : occupancy flags
//   level         : number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module or_out_capture_fifo
  import or_out_capture_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      full,
  output logic                      empty,
  output logic [ptr_w(DEPTH)-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Same index with differing MSB means the writer is a full lap ahead.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // NOTE: the storage array has no reset; the pointers alone decide which
  // slots hold valid data, and the empty mask below hides stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/or_out_capture.sv
// -----------------------------------------------------------------------------
// or_out_capture
// Receive-side capture for the OR_out bus. Samples y every clock, records a
// baseline event on enable and a change event whenever the sampled value
// differs from the previous enabled sample, and queues events in a FWFT FIFO
// read over a valid/ready port.
// Configuration macro: OR_OUT_CAPTURE_TS_EN
//   defined   : free-running timestamp counter, rd_ts carries event time
//   undefined : no counter or timestamp storage, rd_ts reads 0
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   y                 : OR_out bus result word
//   cap_en            : capture enable; dropping it re-arms the baseline
//   rd_valid/rd_ready : read handshake, pop on valid && ready
//   rd_data, rd_ts    : head entry (0 when empty)
//   level             : FIFO occupancy
//   overflow, clr_ovf : sticky drop flag and its clear (a new drop wins)
// -----------------------------------------------------------------------------
module or_out_capture
  import or_out_capture_pkg::*;
#(
  parameter int OR_out_WIDTH = OR_OUT_WIDTH_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int TS_WIDTH     = TS_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [OR_out_WIDTH-1:0]  y,
  input  logic                     cap_en,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [OR_out_WIDTH-1:0]  rd_data,
  output logic [TS_WIDTH-1:0]      rd_ts,
  output logic [ptr_w(DEPTH)-1:0]  level,
  output logic                     overflow,
  input  logic                     clr_ovf
);

`ifdef OR_OUT_CAPTURE_TS_EN
  typedef struct packed {
    logic [OR_out_WIDTH-1:0] data;
    logic [TS_WIDTH-1:0]     ts;
  } slot_t;
`else
  typedef struct packed {
    logic [OR_out_WIDTH-1:0] data;
  } slot_t;
`endif

  logic [OR_out_WIDTH-1:0] y_q;
  logic [OR_out_WIDTH-1:0] y_prev;
  logic                    q_vld;   // y_q holds a real sample (first edge after reset done)
  logic                    armed;
  logic                    evt;
  logic                    pop;
  logic                    drop;
  logic                    full;
  logic                    empty;
  slot_t                   wr_slot;
  slot_t                   rd_slot;

`ifdef OR_OUT_CAPTURE_TS_EN
  logic [TS_WIDTH-1:0] ts;

  // Free-running; wraps silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts <= '0;
    else      ts <= ts + TS_WIDTH'(1);
  end
`endif

  // Sample stage and change-detector state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q    <= '0;
      y_prev <= '0;
      q_vld  <= 1'b0;
      armed  <= 1'b0;
    end else begin
      y_q   <= y;
      q_vld <= 1'b1;
      if (cap_en && q_vld) begin
        armed  <= 1'b1;
        y_prev <= y_q;
      end else if (!cap_en) begin
        armed  <= 1'b0;
      end
    end
  end

  // Unarmed: baseline event. Armed: event only on a change of the sample.
  assign evt  = cap_en && q_vld && (!armed || (y_q != y_prev));
  assign pop  = rd_valid && rd_ready;
  assign drop = evt && full && !pop;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_slot      = '0;
    wr_slot.data = y_q;
`ifdef OR_OUT_CAPTURE_TS_EN
    wr_slot.ts   = ts;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  or_out_capture_fifo #(
    .WIDTH ($bits(slot_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (evt),
    .wr_data (wr_slot),
    .pop     (pop),
    .rd_data (rd_slot),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign rd_valid = !empty;
  assign rd_data  = rd_slot.data;
`ifdef OR_OUT_CAPTURE_TS_EN
  assign rd_ts    = rd_slot.ts;
`else
  assign rd_ts    = '0;
`endif

endmodule

// File: tb/tb_or_out_capture.sv
// -----------------------------------------------------------------------------
// tb_or_out_capture
// Self-checking bench for or_out_capture: a directed vector table for the
// baseline / change stream, hand-written sequences for overflow, full with
// simultaneous pop, enable gating and asynchronous reset, then randomized
// traffic checked against a queue-based reference model.
// Expected timestamps follow OR_OUT_CAPTURE_TS_EN (0 when undefined).
// -----------------------------------------------------------------------------
module tb_or_out_capture;
  import or_out_capture_pkg::*;

  localparam int W  = OR_OUT_WIDTH_DEF;
  localparam int D  = DEPTH_DEF;
  localparam int TW = TS_WIDTH_DEF;
  localparam int LW = PTR_W_DEF;

`ifdef OR_OUT_CAPTURE_TS_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  y;
  logic          cap_en;
  logic          rd_valid;
  logic          rd_ready;
  logic [W-1:0]  rd_data;
  logic [TW-1:0] rd_ts;
  logic [LW-1:0] level;
  logic          overflow;
  logic          clr_ovf;

  int errors = 0;
  int checks = 0;

  or_out_capture dut (
    .clk      (clk),
    .rst      (rst),
    .y        (y),
    .cap_en   (cap_en),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_ts    (rd_ts),
    .level    (level),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ets(input int t);
    logic [TW-1:0] tv;
    tv = TS_ON ? t[TW-1:0] : '0;
    return {16'h0, tv};
  endfunction

  // One clock: drive inputs just after the rising edge, return on the
  // falling edge so outputs reflect the state after that rising edge.
  task automatic cyc(input logic [W-1:0] yv, input logic c, input logic r, input logic cl);
    @(posedge clk);
    #1;
    y = yv; cap_en = c; rd_ready = r; clr_ovf = cl;
    @(negedge clk);
  endtask

  // Directed table: inputs driven for the cycle, expected outputs observed
  // after the edge that opens that cycle.
  typedef struct {
    logic [W-1:0] y;
    logic         cap;
    logic         rdy;
    logic         v;
    logic [W-1:0] d;
    int           ts;
    int           lvl;
  } vec_t;

  vec_t tbl[11];

  // Reference model state (random phase).
  entry_t       mq[$];
  logic [W-1:0] m_samp, m_last;
  bit           m_samp_vld, m_armed, m_ovf;
  int           m_cyc;
  logic [W-1:0] cy;
  bit           cc, cr, cl;
  logic [W-1:0] pool[4];
  logic [W-1:0] drain_exp[8];

  // Applies the rules for the cycle that just ended at this edge.
  task automatic model_edge();
    bit     ev;
    bit     popped;
    entry_t e;
    ev = 1'b0;
    if (cc && m_samp_vld) begin
      // first enabled sample is always recorded, later ones only if different
      ev      = !m_armed || (m_samp != m_last);
      m_last  = m_samp;
      m_armed = 1'b1;
    end else if (!cc) begin
      m_armed = 1'b0;
    end
    popped = (mq.size() != 0) && cr;
    if (popped) void'(mq.pop_front());
    if (ev && mq.size() == D) begin
      m_ovf = 1'b1;
    end else begin
      if (ev) begin
        e.data = m_samp;
        e.ts   = ets(m_cyc);
        mq.push_back(e);
      end
      if (cl) m_ovf = 1'b0;
    end
    m_samp     = cy;
    m_samp_vld = 1'b1;
    m_cyc++;
  endtask

  initial begin
    tbl[0]  = '{8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0};
    tbl[1]  = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1, 1};
    tbl[2]  = '{8'h01, 1'b1, 1'b0, 1'b1, 8'h00, 1, 1};
    tbl[3]  = '{8'h01, 1'b1, 1'b1, 1'b1, 8'h00, 1, 1};
    tbl[4]  = '{8'h03, 1'b1, 1'b1, 1'b1, 8'h01, 4, 1};
    tbl[5]  = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0};
    tbl[6]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'h03, 6, 1};
    tbl[7]  = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 7, 1};
    tbl[8]  = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 7, 1};
    tbl[9]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 7, 1};
    tbl[10] = '{8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 0, 0};
    drain_exp = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h55};
    pool = '{8'h00, 8'h0F, 8'hF0, 8'hFF};

    // ---- reset state ----
    rst = 1'b1; y = '0; cap_en = 1'b1; rd_ready = 1'b0; clr_ovf = 1'b0;
    #1 rst = 1'b0;
    #20;
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset rd_data",  32'(rd_data),  32'd0);
    check("reset rd_ts",    32'(rd_ts),    32'd0);
    check("reset level",    32'(level),    32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ---- baseline and change stream (table) ----
    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].y, tbl[i].cap, tbl[i].rdy, 1'b0);
      check($sformatf("tbl[%0d] rd_valid", i), 32'(rd_valid), 32'(tbl[i].v));
      check($sformatf("tbl[%0d] rd_data", i),  32'(rd_data),  32'(tbl[i].d));
      check($sformatf("tbl[%0d] rd_ts", i),    32'(rd_ts),    ets(tbl[i].ts));
      check($sformatf("tbl[%0d] level", i),    32'(level),    32'(tbl[i].lvl));
    end

    // ---- overflow: 12 toggles with no reader ----
    for (int i = 0; i < 12; i++) cyc((i % 2 == 0) ? 8'h00 : 8'hFF, 1'b1, 1'b0, 1'b0);
    cyc(8'hFF, 1'b1, 1'b0, 1'b0);
    cyc(8'hFF, 1'b1, 1'b0, 1'b0);
    check("ovf level",    32'(level),    32'(D));
    check("ovf flag",     32'(overflow), 32'd1);
    check("ovf head",     32'(rd_data),  32'h00);
    cyc(8'hFF, 1'b1, 1'b0, 1'b1);
    check("ovf before clear", 32'(overflow), 32'd1);
    cyc(8'hFF, 1'b1, 1'b0, 1'b0);
    check("ovf cleared",  32'(overflow), 32'd0);
    check("ovf level kept", 32'(level),  32'(D));

    // ---- full with simultaneous pop ----
    cyc(8'h55, 1'b1, 1'b0, 1'b0);
    cyc(8'h55, 1'b1, 1'b1, 1'b0);
    cyc(8'h55, 1'b1, 1'b0, 1'b0);
    check("fullpop level",    32'(level),    32'(D));
    check("fullpop overflow", 32'(overflow), 32'd0);
    for (int k = 0; k < 8; k++) begin
      cyc(8'h55, 1'b1, 1'b1, 1'b0);
      check($sformatf("drain[%0d] data", k),  32'(rd_data), 32'(drain_exp[k]));
      check($sformatf("drain[%0d] level", k), 32'(level),   32'(D - k));
    end
    cyc(8'h55, 1'b1, 1'b0, 1'b0);
    check("drained rd_valid", 32'(rd_valid), 32'd0);
    check("drained level",    32'(level),    32'd0);

    // ---- enable gating and re-arm ----
    cyc(8'h0F, 1'b0, 1'b0, 1'b0);
    cyc(8'hF0, 1'b0, 1'b0, 1'b0);
    cyc(8'hF0, 1'b0, 1'b0, 1'b0);
    cyc(8'hF0, 1'b0, 1'b0, 1'b0);
    check("gated level", 32'(level), 32'd0);
    cyc(8'hF0, 1'b1, 1'b0, 1'b0);
    cyc(8'hF0, 1'b1, 1'b0, 1'b0);
    check("rearm level", 32'(level),   32'd1);
    check("rearm data",  32'(rd_data), 32'hF0);
    cyc(8'hF0, 1'b1, 1'b0, 1'b0);
    check("rearm single", 32'(level),  32'd1);

    // ---- asynchronous reset mid-stream ----
    cyc(8'h01, 1'b1, 1'b0, 1'b0);
    cyc(8'h02, 1'b1, 1'b0, 1'b0);
    cyc(8'h03, 1'b1, 1'b0, 1'b0);
    cyc(8'h04, 1'b1, 1'b0, 1'b0);
    cyc(8'h04, 1'b1, 1'b0, 1'b0);
    cyc(8'h04, 1'b1, 1'b0, 1'b0);
    check("pre-reset level", 32'(level), 32'd5);
    #2 rst = 1'b0;
    #1;
    check("async rst rd_valid", 32'(rd_valid), 32'd0);
    check("async rst level",    32'(level),    32'd0);
    check("async rst overflow", 32'(overflow), 32'd0);
    check("async rst rd_data",  32'(rd_data),  32'd0);

    // ---- randomized traffic against the reference model ----
    @(negedge clk);
    mq.delete();
    m_samp = '0; m_last = '0; m_samp_vld = 1'b0; m_armed = 1'b0; m_ovf = 1'b0;
    m_cyc = 0;
    cy = pool[$urandom_range(0, 3)]; cc = 1'b1; cr = 1'b0; cl = 1'b0;
    y = cy; cap_en = cc; rd_ready = cr; clr_ovf = cl;
    rst = 1'b1;
    for (int it = 0; it < 400; it++) begin
      @(posedge clk);
      model_edge();
      #1;
      cy = ($urandom_range(0, 7) == 0) ? W'($urandom) : pool[$urandom_range(0, 3)];
      cc = ($urandom_range(0, 7) != 0);
      cr = ($urandom_range(0, 9) < 4);
      cl = ($urandom_range(0, 7) == 0);
      y = cy; cap_en = cc; rd_ready = cr; clr_ovf = cl;
      @(negedge clk);
      check("rnd rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
      check("rnd rd_data",  32'(rd_data),  (mq.size() != 0) ? 32'(mq[0].data) : 32'd0);
      check("rnd rd_ts",    32'(rd_ts),    (mq.size() != 0) ? 32'(mq[0].ts)   : 32'd0);
      check("rnd level",    32'(level),    32'(mq.size()));
      check("rnd overflow", 32'(overflow), 32'(m_ovf));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
